// File: rtl/dcm_phase_stepper_pkg.sv
// Shared x353 DCM constants: phase-stepper state encoding and parameter defaults.
package dcm_phase_stepper_pkg;

    localparam int DCM_PS_WIDTH   = 8;
    localparam int DCM_PS_TIMEOUT = 63;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } ps_state_t;

endpackage

// File: rtl/dcm_phase_stepper.sv
// Walks a DCM fine phase shift one PSEN step at a time toward a written signed target,
// tracking completed steps and flagging steps whose PSDONE never arrives.
module dcm_phase_stepper
    import dcm_phase_stepper_pkg::*;
#(
    parameter int WIDTH   = DCM_PS_WIDTH,
    parameter int TIMEOUT = DCM_PS_TIMEOUT
) (
    input  logic                    dcm_clk,
    input  logic                    dcm_rst,
    input  logic                    wen,
    input  logic signed [WIDTH-1:0] wdata,
    input  logic                    locked,
    input  logic                    ps_done,
    output logic                    ps_en,
    output logic                    ps_incdec,
    output logic signed [WIDTH-1:0] cur_phase,
    output logic                    busy,
    output logic                    err
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    ps_state_t               state, state_d;
    logic signed [WIDTH-1:0] target, target_d;
    logic signed [WIDTH-1:0] cur_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic                    incdec_d;
    logic                    err_d;
    logic                    busy_d;
    logic                    en_d;

    always_ff @(posedge dcm_clk or posedge dcm_rst) begin
        if (dcm_rst) begin
            state     <= IDLE;
            target    <= '0;
            cur_phase <= '0;
            cnt       <= '0;
            ps_en     <= 1'b0;
            ps_incdec <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            target    <= target_d;
            cur_phase <= cur_d;
            cnt       <= cnt_d;
            ps_en     <= en_d;
            ps_incdec <= incdec_d;
            err       <= err_d;
            busy      <= busy_d;
        end
    end

    // PSEN is the registered image of PULSE, so the strobe lands one cycle after the decision.
    always_comb begin
        state_d  = state;
        target_d = wen ? wdata : target;
        cur_d    = cur_phase;
        cnt_d    = cnt;
        incdec_d = ps_incdec;
        err_d    = err;
        en_d     = (state == PULSE);

        case (state)
            IDLE: begin
                if (locked && !err && (target != cur_phase)) begin
                    state_d  = PULSE;
                    incdec_d = (target > cur_phase);
                end
            end
            PULSE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (ps_done) begin
                    cur_d   = ps_incdec ? cur_phase + WIDTH'(1) : cur_phase - WIDTH'(1);
                    state_d = GAP;
                end else if (cnt == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wen) begin
            err_d = 1'b0;
        end

        busy_d = (state_d != IDLE) || (target_d != cur_d);
    end

endmodule

// File: tb/tb_dcm_phase_stepper.sv
// Self-checking bench for dcm_phase_stepper: timing-rule reference model, DCM responder,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dcm_phase_stepper;

    localparam int W  = 8;
    localparam int TO = 63;

    logic                dcm_clk = 1'b0;
    logic                dcm_rst = 1'b1;
    logic                wen     = 1'b0;
    logic signed [W-1:0] wdata   = '0;
    logic                locked  = 1'b1;
    logic                ps_done = 1'b0;
    logic                ps_en;
    logic                ps_incdec;
    logic signed [W-1:0] cur_phase;
    logic                busy;
    logic                err;

    dcm_phase_stepper #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .dcm_clk   (dcm_clk),
        .dcm_rst   (dcm_rst),
        .wen       (wen),
        .wdata     (wdata),
        .locked    (locked),
        .ps_done   (ps_done),
        .ps_en     (ps_en),
        .ps_incdec (ps_incdec),
        .cur_phase (cur_phase),
        .busy      (busy),
        .err       (err)
    );

    always #5 dcm_clk = ~dcm_clk;

    // DCM responder: PSDONE dcm_lat cycles after each PSEN (0 = never), plus optional stray pulses.
    int dcm_lat  = 5;
    bit spur_en  = 1'b0;
    int done_cnt = 0;
    always @(posedge dcm_clk) begin
        #1;
        ps_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt = done_cnt - 1;
            if (done_cnt == 0) ps_done = 1'b1;
        end
        if (ps_en && dcm_lat > 0) done_cnt = dcm_lat;
        if (spur_en && $urandom_range(0, 15) == 0) ps_done = 1'b1;
    end

    // Reference model in terms of edge numbers: a step decided at edge d strobes PSEN at d+1,
    // accepts PSDONE on edges d+2..d+TO+1, and times out at d+TO+1 if none came.
    int                  t        = 0;
    int                  m_issue  = 0;
    int                  m_ready  = 0;
    bit                  m_active = 1'b0;
    logic signed [W-1:0] m_target = '0;
    logic signed [W-1:0] m_cur    = '0;
    logic                m_err    = 1'b0;
    logic                m_busy   = 1'b0;
    logic                m_dir    = 1'b0;
    logic                m_en     = 1'b0;

    always @(posedge dcm_clk or posedge dcm_rst) begin : model_step
        int                  age;
        bit                  n_gap;
        logic signed [W-1:0] n_target;
        logic signed [W-1:0] n_cur;
        logic                n_err;
        logic                n_en;
        if (dcm_rst) begin
            m_active = 1'b0;
            m_ready  = 0;
            m_target = '0;
            m_cur    = '0;
            m_err    = 1'b0;
            m_busy   = 1'b0;
            m_dir    = 1'b0;
            m_en     = 1'b0;
        end else begin
            t        = t + 1;
            n_target = wen ? wdata : m_target;
            n_cur    = m_cur;
            n_err    = m_err;
            n_en     = 1'b0;
            n_gap    = 1'b0;
            if (m_active) begin
                age = t - m_issue;
                if (age == 1) begin
                    n_en = 1'b1;
                end else if (ps_done) begin
                    n_cur    = m_dir ? m_cur + 8'sd1 : m_cur - 8'sd1;
                    m_active = 1'b0;
                    n_gap    = 1'b1;
                    m_ready  = t + 2;
                end else if (age == TO + 1) begin
                    n_err    = 1'b1;
                    m_active = 1'b0;
                    m_ready  = t + 1;
                end
            end else if (t >= m_ready && locked && !m_err && m_target != m_cur) begin
                m_active = 1'b1;
                m_issue  = t;
                m_dir    = (m_target > m_cur);
            end
            if (wen) n_err = 1'b0;
            m_target = n_target;
            m_cur    = n_cur;
            m_err    = n_err;
            m_en     = n_en;
            m_busy   = m_active || n_gap || (n_target != n_cur);
        end
    end

    int nchk      = 0;
    int nerr      = 0;
    int pulse_cnt = 0;
    int inc_cnt   = 0;

    task automatic checkOutput(input string name, input int got, input int exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge dcm_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic signed [W-1:0] v);
        wen   = 1'b1;
        wdata = v;
        tick(1);
        wen   = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int i = 0;
        while ((busy || m_busy) && i < budget) begin
            tick(1);
            i++;
        end
        nchk++;
        if (busy || m_busy) begin
            nerr++;
            $display("[TB] FAIL %s: busy=%b after %0d cycles, expected busy=0", name, busy, budget);
        end
    endtask

    task automatic waitForEn(input string name, input int budget);
        int i = 0;
        do begin
            @(negedge dcm_clk);
            i++;
        end while (!ps_en && i < budget);
        nchk++;
        if (!ps_en) begin
            nerr++;
            $display("[TB] FAIL %s: ps_en=0 after %0d cycles, expected ps_en=1", name, budget);
        end
    endtask

    task automatic waitCur(input string name, input int v, input int budget);
        int i = 0;
        do begin
            @(negedge dcm_clk);
            i++;
        end while (int'(cur_phase) != v && i < budget);
        checkOutput(name, int'(cur_phase), v);
    endtask

    initial begin
        fork
            begin : stimulus
                int n;
                int v;
                int r;
                tick(3);
                checkOutput("reset_cur", int'(cur_phase), 0);
                checkOutput("reset_busy", int'(busy), 0);
                checkOutput("reset_err", int'(err), 0);
                checkOutput("reset_en", int'(ps_en), 0);
                checkOutput("reset_dir", int'(ps_incdec), 0);
                dcm_rst = 1'b0;
                tick(2);

                // Up to +3: PSEN on the second edge after the write edge.
                pulse_cnt = 0;
                inc_cnt   = 0;
                wen   = 1'b1;
                wdata = 8'sd3;
                @(posedge dcm_clk);
                #1 wen = 1'b0;
                @(negedge dcm_clk);
                checkOutput("lat_edge0_en", int'(ps_en), 0);
                @(negedge dcm_clk);
                checkOutput("lat_edge1_en", int'(ps_en), 0);
                @(negedge dcm_clk);
                checkOutput("lat_edge2_en", int'(ps_en), 1);
                checkOutput("lat_edge2_dir", int'(ps_incdec), 1);
                waitIdle("idle_up3", 200);
                checkOutput("up3_cur", int'(cur_phase), 3);
                checkOutput("up3_pulses", pulse_cnt, 3);
                checkOutput("up3_inc", inc_cnt, 3);

                // Down to -2 (0xFE): five decrements.
                pulse_cnt = 0;
                inc_cnt   = 0;
                applyStimulus(-8'sd2);
                waitIdle("idle_dn", 300);
                checkOutput("dn_cur", int'(cur_phase), -2);
                checkOutput("dn_pulses", pulse_cnt, 5);
                checkOutput("dn_inc", inc_cnt, 0);

                // PSDONE withheld: error after 63 WAIT cycles, then stalled until a write.
                dcm_lat = 0;
                applyStimulus(8'sd0);
                waitForEn("to_en", 20);
                n = 0;
                do begin
                    @(negedge dcm_clk);
                    n++;
                end while (!err && n < 200);
                checkOutput("to_cycles", n, 63);
                checkOutput("to_cur", int'(cur_phase), -2);
                pulse_cnt = 0;
                tick(20);
                checkOutput("to_stalled_pulses", pulse_cnt, 0);
                checkOutput("to_err_sticky", int'(err), 1);
                dcm_lat   = 5;
                pulse_cnt = 0;
                applyStimulus(8'sd0);
                checkOutput("to_err_cleared", int'(err), 0);
                waitIdle("idle_resume", 200);
                checkOutput("resume_cur", int'(cur_phase), 0);
                checkOutput("resume_pulses", pulse_cnt, 2);

                // PSDONE on the final WAIT cycle beats the timeout; one cycle later loses.
                dcm_lat = 62;
                applyStimulus(8'sd1);
                waitIdle("idle_l62", 300);
                checkOutput("l62_cur", int'(cur_phase), 1);
                checkOutput("l62_err", int'(err), 0);
                dcm_lat = 63;
                applyStimulus(8'sd2);
                waitForEn("l63_en", 20);
                tick(80);
                checkOutput("l63_err", int'(err), 1);
                checkOutput("l63_cur", int'(cur_phase), 1);
                dcm_lat = 5;
                applyStimulus(8'sd0);
                waitIdle("idle_back0", 200);

                // locked=0 holds off stepping.
                locked    = 1'b0;
                pulse_cnt = 0;
                applyStimulus(8'sd2);
                tick(30);
                checkOutput("unlk_pulses", pulse_cnt, 0);
                checkOutput("unlk_busy", int'(busy), 1);
                locked = 1'b1;
                waitIdle("idle_lock", 200);
                checkOutput("lock_cur", int'(cur_phase), 2);
                checkOutput("lock_pulses", pulse_cnt, 2);

                // Retarget during WAIT: outstanding step completes, then reverses.
                applyStimulus(8'sd0);
                waitIdle("idle_pre_rt", 200);
                pulse_cnt = 0;
                inc_cnt   = 0;
                applyStimulus(8'sd4);
                waitForEn("rt_en", 20);
                applyStimulus(8'sd0);
                waitIdle("idle_rt", 200);
                checkOutput("rt_cur", int'(cur_phase), 0);
                checkOutput("rt_pulses", pulse_cnt, 2);
                checkOutput("rt_inc", inc_cnt, 1);

                // Reset while in WAIT at cur_phase=2; the late PSDONE must be ignored.
                applyStimulus(8'sd4);
                waitCur("rst_reach2", 2, 200);
                waitForEn("rst_en", 20);
                #2 dcm_rst = 1'b1;
                #1;
                checkOutput("rst_en", int'(ps_en), 0);
                checkOutput("rst_cur", int'(cur_phase), 0);
                checkOutput("rst_busy", int'(busy), 0);
                checkOutput("rst_dir", int'(ps_incdec), 0);
                tick(2);
                dcm_rst   = 1'b0;
                pulse_cnt = 0;
                tick(20);
                checkOutput("rst_after_cur", int'(cur_phase), 0);
                checkOutput("rst_after_pulses", pulse_cnt, 0);
                checkOutput("rst_after_busy", int'(busy), 0);

                // Random traffic against the model.
                spur_en = 1'b1;
                repeat (3000) begin
                    tick(1);
                    wen    = ($urandom_range(0, 24) == 0);
                    v      = int'($urandom_range(0, 20)) - 10;
                    wdata  = W'(v);
                    locked = ($urandom_range(0, 9) != 0);
                    if (wen) begin
                        r = int'($urandom_range(0, 19));
                        case (r)
                            0:       dcm_lat = 0;
                            1:       dcm_lat = 62;
                            2:       dcm_lat = 63;
                            3:       dcm_lat = 70;
                            default: dcm_lat = int'($urandom_range(1, 8));
                        endcase
                    end
                    if ($urandom_range(0, 999) == 0) begin
                        dcm_rst = 1'b1;
                        tick(2);
                        dcm_rst = 1'b0;
                    end
                end
                wen     = 1'b0;
                spur_en = 1'b0;
                locked  = 1'b1;
                dcm_lat = 3;
                tick(80);
                applyStimulus(8'sd0);
                waitIdle("idle_final", 2000);
                checkOutput("final_cur", int'(cur_phase), 0);
                tick(5);
            end
            begin : compare
                forever begin
                    @(negedge dcm_clk);
                    nchk++;
                    if (ps_en !== m_en || ps_incdec !== m_dir || cur_phase !== m_cur ||
                        busy !== m_busy || err !== m_err) begin
                        nerr++;
                        $display("[TB] FAIL model_cmp t=%0d: got en=%b dir=%b cur=%0d busy=%b err=%b, expected en=%b dir=%b cur=%0d busy=%b err=%b",
                                 t, ps_en, ps_incdec, cur_phase, busy, err,
                                 m_en, m_dir, m_cur, m_busy, m_err);
                    end
                    if (ps_en === 1'b1) begin
                        pulse_cnt++;
                        if (ps_incdec === 1'b1) inc_cnt++;
                    end
                end
            end
        join_any
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
